// File: rtl/multicycle_control_if.sv
// multicycle_control_if: bundle between the multicycle controller and its datapath.
// Carries instruction fields and ALU flag toward the controller and strobes/selects back.
// master = controller, slave = datapath. MULTICYCLE_MEM_WAIT_EN adds mem_ready.
interface multicycle_control_if;
    logic [6:0] inst_opcode;
    logic [2:0] inst_funct3;
    logic [6:0] inst_funct7;
    logic       alu_result_equal_zero;
`ifdef MULTICYCLE_MEM_WAIT_EN
    logic       mem_ready;
`endif
    logic       pc_write_enable;
    logic       alu_out_write_enable;
    logic       inst_write_enable;
    logic       data_write_enable;
    logic       regfile_write_enable;
    logic       mem_read_enable;
    logic       mem_write_enable;
    logic       mem_to_reg;
    logic       inst_or_data;
    logic       next_pc_select;
    logic [1:0] alu_operand_a_select;
    logic [1:0] alu_operand_b_select;
    logic [4:0] alu_function;
    logic       trap;

    modport master (
        input  inst_opcode, inst_funct3, inst_funct7, alu_result_equal_zero,
`ifdef MULTICYCLE_MEM_WAIT_EN
        input  mem_ready,
`endif
        output pc_write_enable, alu_out_write_enable, inst_write_enable,
        output data_write_enable, regfile_write_enable,
        output mem_read_enable, mem_write_enable,
        output mem_to_reg, inst_or_data, next_pc_select,
        output alu_operand_a_select, alu_operand_b_select,
        output alu_function, trap
    );

    modport slave (
        output inst_opcode, inst_funct3, inst_funct7, alu_result_equal_zero,
`ifdef MULTICYCLE_MEM_WAIT_EN
        output mem_ready,
`endif
        input  pc_write_enable, alu_out_write_enable, inst_write_enable,
        input  data_write_enable, regfile_write_enable,
        input  mem_read_enable, mem_write_enable,
        input  mem_to_reg, inst_or_data, next_pc_select,
        input  alu_operand_a_select, alu_operand_b_select,
        input  alu_function, trap
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing an RV32I multicycle datapath.
// Ports: clock, reset (sync, active-high), bus (multicycle_control_if.master).
// Optional macro MULTICYCLE_MEM_WAIT_EN: memory states stall on bus.mem_ready.
module multicycle_control (
    input logic                 clock,
    input logic                 reset,
    multicycle_control_if.master bus
);
    localparam logic [4:0] F_ADD  = 5'd0;
    localparam logic [4:0] F_SUB  = 5'd1;
    localparam logic [4:0] F_SLL  = 5'd2;
    localparam logic [4:0] F_SLT  = 5'd3;
    localparam logic [4:0] F_SLTU = 5'd4;
    localparam logic [4:0] F_XOR  = 5'd5;
    localparam logic [4:0] F_SRL  = 5'd6;
    localparam logic [4:0] F_SRA  = 5'd7;
    localparam logic [4:0] F_OR   = 5'd8;
    localparam logic [4:0] F_AND  = 5'd9;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;
    localparam logic [1:0] B_RS2  = 2'd0;
    localparam logic [1:0] B_IMM  = 2'd1;
    localparam logic [1:0] B_FOUR = 2'd2;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_ALU, EXEC_IMM, MEM_ADDR, MEM_READ, MEM_WB,
        MEM_WRITE, ALU_WB, BRANCH, BRANCH_NT, JUMP, JUMP_WB, TRAP
    } state_t;

    typedef struct packed {
        logic       trap;
        logic       pc_we;
        logic       alu_out_we;
        logic       inst_we;
        logic       data_we;
        logic       rf_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem_to_reg;
        logic       inst_or_data;
        logic       next_pc_sel;
        logic [1:0] a_sel;
        logic [1:0] b_sel;
        logic [4:0] alu_fn;
    } ctrl_t;

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_nxt;
    ctrl_t  ctrl_out;
    logic   mem_ready;
    logic   taken;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_ready = bus.mem_ready;
`else
    assign mem_ready = 1'b1;
`endif

    function automatic logic [4:0] alu_fn(input logic [2:0] f3, input logic alt);
        logic [4:0] fn;
        case (f3)
            3'b000:  fn = alt ? F_SUB : F_ADD;
            3'b001:  fn = F_SLL;
            3'b010:  fn = F_SLT;
            3'b011:  fn = F_SLTU;
            3'b100:  fn = F_XOR;
            3'b101:  fn = alt ? F_SRA : F_SRL;
            3'b110:  fn = F_OR;
            default: fn = F_AND;
        endcase
        return fn;
    endfunction

    // Branch compare: SUB for EQ/NE, SLT/SLTU for signed/unsigned ordering.
    function automatic logic [4:0] branch_fn(input logic [2:0] f3);
        logic [4:0] fn;
        if (!f3[2])
            fn = F_SUB;
        else if (f3[1])
            fn = F_SLTU;
        else
            fn = F_SLT;
        return fn;
    endfunction

    function automatic ctrl_t moore(
        input state_t     s,
        input logic [6:0] opc,
        input logic [2:0] f3,
        input logic [6:0] f7
    );
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_rd  = 1'b1;
                c.inst_we = 1'b1;
            end
            DECODE: begin
                c.a_sel      = A_PC;
                c.b_sel      = B_IMM;
                c.alu_out_we = 1'b1;
            end
            EXEC_ALU: begin
                c.a_sel      = A_RS1;
                c.b_sel      = B_RS2;
                c.alu_fn     = alu_fn(f3, f7[5]);
                c.alu_out_we = 1'b1;
            end
            EXEC_IMM: begin
                c.alu_out_we = 1'b1;
                c.b_sel      = B_IMM;
                case (opc)
                    OPC_LUI:   c.a_sel = A_ZERO;
                    OPC_AUIPC: c.a_sel = A_PC;
                    OPC_JALR:  c.a_sel = A_RS1;
                    default: begin
                        c.a_sel  = A_RS1;
                        c.alu_fn = alu_fn(f3, (f3 == 3'b101) && f7[5]);
                    end
                endcase
            end
            MEM_ADDR: begin
                c.a_sel      = A_RS1;
                c.b_sel      = B_IMM;
                c.alu_out_we = 1'b1;
            end
            MEM_READ: begin
                c.inst_or_data = 1'b1;
                c.mem_rd       = 1'b1;
                c.data_we      = 1'b1;
            end
            MEM_WB: begin
                c.rf_we      = 1'b1;
                c.mem_to_reg = 1'b1;
                c.a_sel      = A_PC;
                c.b_sel      = B_FOUR;
                c.pc_we      = 1'b1;
            end
            MEM_WRITE: begin
                c.inst_or_data = 1'b1;
                c.mem_wr       = 1'b1;
                c.a_sel        = A_PC;
                c.b_sel        = B_FOUR;
                c.pc_we        = 1'b1;
            end
            ALU_WB: begin
                c.rf_we = 1'b1;
                c.a_sel = A_PC;
                c.b_sel = B_FOUR;
                c.pc_we = 1'b1;
            end
            BRANCH: begin
                c.a_sel  = A_RS1;
                c.b_sel  = B_RS2;
                c.alu_fn = branch_fn(f3);
                c.pc_we  = 1'b1;
            end
            BRANCH_NT: begin
                c.a_sel = A_PC;
                c.b_sel = B_FOUR;
                c.pc_we = 1'b1;
            end
            JUMP: begin
                c.pc_we       = 1'b1;
                c.next_pc_sel = 1'b1;
                c.a_sel       = A_PC;
                c.b_sel       = B_FOUR;
                c.alu_out_we  = 1'b1;
            end
            JUMP_WB: c.rf_we = 1'b1;
            TRAP:    c.trap  = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        case (bus.inst_funct3)
            3'b000, 3'b101, 3'b111: taken = bus.alu_result_equal_zero;
            default:                taken = !bus.alu_result_equal_zero;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: if (mem_ready) state_nxt = DECODE;
            DECODE: begin
                case (bus.inst_opcode)
                    OPC_OP:     state_nxt = EXEC_ALU;
                    OPC_OP_IMM,
                    OPC_LUI,
                    OPC_AUIPC,
                    OPC_JALR:   state_nxt = EXEC_IMM;
                    OPC_LOAD,
                    OPC_STORE:  state_nxt = MEM_ADDR;
                    OPC_BRANCH: state_nxt =
                        (bus.inst_funct3[2:1] == 2'b01) ? TRAP : BRANCH;
                    OPC_JAL:    state_nxt = JUMP;
                    default:    state_nxt = TRAP;
                endcase
            end
            EXEC_ALU: state_nxt = ALU_WB;
            EXEC_IMM: state_nxt =
                (bus.inst_opcode == OPC_JALR) ? JUMP : ALU_WB;
            MEM_ADDR: state_nxt =
                (bus.inst_opcode == OPC_LOAD) ? MEM_READ : MEM_WRITE;
            MEM_READ:  if (mem_ready) state_nxt = MEM_WB;
            MEM_WB:    state_nxt = FETCH;
            MEM_WRITE: if (mem_ready) state_nxt = FETCH;
            ALU_WB:    state_nxt = FETCH;
            BRANCH:    state_nxt = taken ? FETCH : BRANCH_NT;
            BRANCH_NT: state_nxt = FETCH;
            JUMP:      state_nxt = JUMP_WB;
            JUMP_WB:   state_nxt = FETCH;
            TRAP:      state_nxt = TRAP;
            default:   state_nxt = FETCH;
        endcase
    end

    assign ctrl_nxt = moore(state_nxt, bus.inst_opcode,
                            bus.inst_funct3, bus.inst_funct7);

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= FETCH;
            ctrl_q <= moore(FETCH, bus.inst_opcode,
                            bus.inst_funct3, bus.inst_funct7);
        end else begin
            state  <= state_nxt;
            ctrl_q <= ctrl_nxt;
        end
    end

    // Memory side effects complete only on a ready cycle; the branch
    // decision is the one output that follows the live zero flag.
    always_comb begin
        ctrl_out         = ctrl_q;
        ctrl_out.inst_we = ctrl_q.inst_we & mem_ready;
        ctrl_out.data_we = ctrl_q.data_we & mem_ready;
        if (state == MEM_WRITE)
            ctrl_out.pc_we = ctrl_q.pc_we & mem_ready;
        if (state == BRANCH) begin
            ctrl_out.pc_we       = ctrl_q.pc_we & taken;
            ctrl_out.next_pc_sel = taken;
        end
        if (reset)
            ctrl_out = '0;
    end

    assign bus.trap                 = ctrl_out.trap;
    assign bus.pc_write_enable      = ctrl_out.pc_we;
    assign bus.alu_out_write_enable = ctrl_out.alu_out_we;
    assign bus.inst_write_enable    = ctrl_out.inst_we;
    assign bus.data_write_enable    = ctrl_out.data_we;
    assign bus.regfile_write_enable = ctrl_out.rf_we;
    assign bus.mem_read_enable      = ctrl_out.mem_rd;
    assign bus.mem_write_enable     = ctrl_out.mem_wr;
    assign bus.mem_to_reg           = ctrl_out.mem_to_reg;
    assign bus.inst_or_data         = ctrl_out.inst_or_data;
    assign bus.next_pc_select       = ctrl_out.next_pc_sel;
    assign bus.alu_operand_a_select = ctrl_out.a_sel;
    assign bus.alu_operand_b_select = ctrl_out.b_sel;
    assign bus.alu_function         = ctrl_out.alu_fn;
endmodule
